// File: rtl/des_core_arbiter_if.sv
// ============================================================================
// Module : des_core_arbiter_if
// Brief  : Requester and DES-core signal bundle for des_core_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface des_core_arbiter_if;
  logic [1:0]   req;
  logic [1:0]   req_mode;
  logic [127:0] req_key;
  logic [127:0] req_text;
  logic [1:0]   ack;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [63:0]  resp_text;
  logic         resp_err;
  logic         core_start_encrypt;
  logic         core_start_decrypt;
  logic [63:0]  core_key;
  logic [63:0]  core_text;
  logic         core_done_encrypt;
  logic         core_done_decrypt;
  logic [63:0]  core_output_text;
  logic         busy;

  modport master (
    input  req, req_mode, req_key, req_text, resp_ready,
    input  core_done_encrypt, core_done_decrypt, core_output_text,
    output ack, resp_valid, resp_text, resp_err,
    output core_start_encrypt, core_start_decrypt, core_key, core_text, busy
  );

  modport slave (
    output req, req_mode, req_key, req_text, resp_ready,
    output core_done_encrypt, core_done_decrypt, core_output_text,
    input  ack, resp_valid, resp_text, resp_err,
    input  core_start_encrypt, core_start_decrypt, core_key, core_text, busy
  );
endinterface

`default_nettype wire

// File: rtl/des_core_arbiter.sv
// ============================================================================
// Module : des_core_arbiter
// Brief  : Round-robin sharing of one DES control core between two requesters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module des_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  wire logic          clk,
  input  wire logic          rst,
  des_core_arbiter_if.master io_bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RELEASE   = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_mode;
  logic [1:0]        r_ack;
  logic [1:0]        r_resp_valid;
  logic              r_resp_err;
  logic [63:0]       r_resp_text;
  logic              r_start_enc;
  logic              r_start_dec;
  logic [63:0]       r_core_key;
  logic [63:0]       r_core_text;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_any_req;
  logic              w_grant;
  logic [63:0]       w_key;
  logic [63:0]       w_text;
  logic              w_mode;
  logic              w_done_any;
  logic              w_flavour_err;
  logic              w_to_last;
  logic              w_ready;

  // Tie goes to the requester that did not win last time.
  assign w_any_req     = |io_bus.req;
  assign w_grant       = (io_bus.req == 2'b11) ? ~r_last_grant : io_bus.req[1];
  assign w_key         = w_grant ? io_bus.req_key[127:64]  : io_bus.req_key[63:0];
  assign w_text        = w_grant ? io_bus.req_text[127:64] : io_bus.req_text[63:0];
  assign w_mode        = io_bus.req_mode[w_grant];
  assign w_done_any    = io_bus.core_done_encrypt | io_bus.core_done_decrypt;
  assign w_flavour_err = r_mode ? ~io_bus.core_done_decrypt : ~io_bus.core_done_encrypt;
  assign w_to_last     = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_ready       = io_bus.resp_ready[r_grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_mode       <= 1'b0;
      r_ack        <= 2'b00;
      r_resp_valid <= 2'b00;
      r_resp_err   <= 1'b0;
      r_resp_text  <= '0;
      r_start_enc  <= 1'b0;
      r_start_dec  <= 1'b0;
      r_core_key   <= '0;
      r_core_text  <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_ack        <= {w_grant, ~w_grant};
            r_core_key   <= w_key;
            r_core_text  <= w_text;
            r_mode       <= w_mode;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_start_enc <= ~r_mode;
          r_start_dec <= r_mode;
          r_to_cnt    <= '0;
          r_state     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (w_done_any) begin
            r_resp_text <= io_bus.core_output_text;
            r_resp_err  <= w_flavour_err;
            r_start_enc <= 1'b0;
            r_start_dec <= 1'b0;
            r_state     <= S_RELEASE;
          end else if (w_to_last) begin
            r_resp_text <= '0;
            r_resp_err  <= 1'b1;
            r_start_enc <= 1'b0;
            r_start_dec <= 1'b0;
            r_state     <= S_RELEASE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_RELEASE: begin
          // Core must be back in its idle state before the result is handed out.
          if (!w_done_any) begin
            r_resp_valid <= {r_grant, ~r_grant};
            r_state      <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (w_ready) begin
            r_resp_valid <= 2'b00;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.ack                = r_ack;
  assign io_bus.resp_valid         = r_resp_valid;
  assign io_bus.resp_text          = r_resp_text;
  assign io_bus.resp_err           = r_resp_err;
  assign io_bus.core_start_encrypt = r_start_enc;
  assign io_bus.core_start_decrypt = r_start_dec;
  assign io_bus.core_key           = r_core_key;
  assign io_bus.core_text          = r_core_text;
  assign io_bus.busy               = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_des_core_arbiter.sv
// ============================================================================
// Module : tb_des_core_arbiter
// Brief  : Directed bench for des_core_arbiter with a behavioural DES core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_des_core_arbiter;

  localparam logic [63:0] C_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] C_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] C_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] C_KA  = 64'h0F0F0F0F0F0F0F0F;
  localparam logic [63:0] C_TA  = 64'h1111111111111111;
  localparam logic [63:0] C_KB  = 64'hF0F0F0F0F0F0F0F0;
  localparam logic [63:0] C_TB  = 64'h2222222222222222;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic m_stall;
  int   m_cnt;

  des_core_arbiter_if bus();

  des_core_arbiter #(.TIMEOUT_CYCLES(64), .TO_W(7)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural core: known DES vector, otherwise text^key; done ~19 cycles after start.
  function automatic logic [63:0] core_fn(input logic dec, input logic [63:0] k, input logic [63:0] t);
    if (!dec && k == C_KEY && t == C_PT) return C_CT;
    if (dec && k == C_KEY && t == C_CT) return C_PT;
    return t ^ k;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt                 <= 0;
      bus.core_done_encrypt <= 1'b0;
      bus.core_done_decrypt <= 1'b0;
      bus.core_output_text  <= '0;
    end else if (!(bus.core_start_encrypt || bus.core_start_decrypt)) begin
      m_cnt                 <= 0;
      bus.core_done_encrypt <= 1'b0;
      bus.core_done_decrypt <= 1'b0;
    end else if (m_stall) begin
      m_cnt <= m_cnt;
    end else if (m_cnt == 18) begin
      bus.core_done_encrypt <= bus.core_start_encrypt;
      bus.core_done_decrypt <= bus.core_start_decrypt;
      bus.core_output_text  <= core_fn(bus.core_start_decrypt, bus.core_key, bus.core_text);
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (bus.ack == 2'b00 && n < 300);
    checks++;
    assert (bus.ack !== 2'b00) else begin
      errors++;
      $error("FAIL %s ack_timeout observed=%b expected=nonzero", tag, bus.ack);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (bus.resp_valid == 2'b00 && n < 300);
    checks++;
    assert (bus.resp_valid !== 2'b00) else begin
      errors++;
      $error("FAIL %s valid_timeout observed=%b expected=nonzero", tag, bus.resp_valid);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (bus.busy && n < 300);
    checks++;
    assert (bus.busy === 1'b0) else begin
      errors++;
      $error("FAIL %s idle_timeout observed=%b expected=0", tag, bus.busy);
    end
  endtask

  initial begin
    logic        ok;
    logic [1:0]  seen_rv;
    logic [63:0] seen_txt;
    logic [63:0] ek, et;
    int          g, cnt;

    checks = 0;
    errors = 0;
    m_stall = 1'b0;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.req_mode = 2'b00;
    bus.req_key = '0;
    bus.req_text = '0;
    bus.resp_ready = 2'b11;

    // Reset state
    repeat (2) tick();
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_err", 64'(bus.resp_err), 64'd0);
    chk("rst_starts", 64'({bus.core_start_encrypt, bus.core_start_decrypt}), 64'd0);
    chk("rst_key", bus.core_key, 64'd0);
    chk("rst_text", bus.core_text, 64'd0);
    chk("rst_resp_text", bus.resp_text, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;

    // 1: requester 0 encrypt
    bus.req_key[63:0] = C_KEY;
    bus.req_text[63:0] = C_PT;
    bus.req_mode = 2'b00;
    bus.req = 2'b01;
    tick();
    chk("t1_ack", 64'(bus.ack), 64'd1);
    chk("t1_core_key", bus.core_key, C_KEY);
    chk("t1_core_text", bus.core_text, C_PT);
    bus.req = 2'b00;
    tick();
    chk("t1_starts", 64'({bus.core_start_encrypt, bus.core_start_decrypt}), 64'b10);
    wait_valid("t1");
    chk("t1_valid", 64'(bus.resp_valid), 64'b01);
    chk("t1_resp_text", bus.resp_text, C_CT);
    chk("t1_err", 64'(bus.resp_err), 64'd0);
    chk("t1_starts_low", 64'({bus.core_start_encrypt, bus.core_start_decrypt}), 64'd0);
    tick();
    chk("t1_valid_clr", 64'(bus.resp_valid), 64'd0);
    chk("t1_idle", 64'(bus.busy), 64'd0);

    // 2: requester 1 decrypt
    bus.req_key[127:64] = C_KEY;
    bus.req_text[127:64] = C_CT;
    bus.req_mode = 2'b10;
    bus.req = 2'b10;
    tick();
    chk("t2_ack", 64'(bus.ack), 64'b10);
    bus.req = 2'b00;
    tick();
    chk("t2_starts", 64'({bus.core_start_encrypt, bus.core_start_decrypt}), 64'b01);
    wait_valid("t2");
    chk("t2_valid", 64'(bus.resp_valid), 64'b10);
    chk("t2_resp_text", bus.resp_text, C_PT);
    chk("t2_err", 64'(bus.resp_err), 64'd0);
    wait_idle("t2");

    // 3: both requesting continuously -> 0,1,0,1
    bus.req_key = {C_KB, C_KA};
    bus.req_text = {C_TB, C_TA};
    bus.req_mode = 2'b00;
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      ek = (g == 1) ? C_KB : C_KA;
      et = (g == 1) ? C_TB : C_TA;
      wait_ack("t3");
      chk("t3_ack_order", 64'(bus.ack), (g == 1) ? 64'b10 : 64'b01);
      chk("t3_core_key", bus.core_key, ek);
      if (i == 3) bus.req = 2'b00;
      ok = 1'b1;
      seen_rv = 2'b00;
      seen_txt = '0;
      for (int n = 0; n < 300; n++) begin
        tick();
        if (!bus.busy) break;
        if (bus.core_key !== ek || bus.core_text !== et) ok = 1'b0;
        if (bus.resp_valid != 2'b00) begin
          seen_rv = bus.resp_valid;
          seen_txt = bus.resp_text;
        end
      end
      chk("t3_key_text_stable", 64'(ok), 64'd1);
      chk("t3_valid_owner", 64'(seen_rv), (g == 1) ? 64'b10 : 64'b01);
      chk("t3_resp_text", seen_txt, et ^ ek);
    end

    // 4: stalled core -> timeout after 64 WAIT_DONE cycles
    m_stall = 1'b1;
    bus.req_key[63:0] = C_KEY;
    bus.req_text[63:0] = C_PT;
    bus.req_mode = 2'b00;
    bus.req = 2'b01;
    wait_ack("t4");
    bus.req = 2'b00;
    cnt = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.core_start_encrypt) cnt++;
      else if (cnt > 0) break;
    end
    chk("t4_start_cycles", 64'(cnt), 64'd64);
    wait_valid("t4");
    chk("t4_valid", 64'(bus.resp_valid), 64'b01);
    chk("t4_err", 64'(bus.resp_err), 64'd1);
    chk("t4_resp_text", bus.resp_text, 64'd0);
    m_stall = 1'b0;
    bus.req_key[127:64] = 64'h00000000FFFFFFFF;
    bus.req_text[127:64] = 64'h123456789ABCDEF0;
    bus.req = 2'b10;
    wait_ack("t4b");
    chk("t4b_ack", 64'(bus.ack), 64'b10);
    bus.req = 2'b00;
    wait_valid("t4b");
    chk("t4b_valid", 64'(bus.resp_valid), 64'b10);
    chk("t4b_err", 64'(bus.resp_err), 64'd0);
    chk("t4b_resp_text", bus.resp_text, 64'h123456786543210F);
    wait_idle("t4b");

    // 5: back-pressure on the response channel
    bus.resp_ready = 2'b00;
    bus.req = 2'b01;
    wait_ack("t5");
    bus.req = 2'b10;
    wait_valid("t5");
    ok = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.resp_valid !== 2'b01 || bus.resp_text !== C_CT || bus.ack !== 2'b00 || bus.busy !== 1'b1)
        ok = 1'b0;
    end
    chk("t5_hold", 64'(ok), 64'd1);
    bus.resp_ready = 2'b11;
    tick();
    chk("t5_valid_clr", 64'(bus.resp_valid), 64'd0);
    tick();
    chk("t5_next_ack", 64'(bus.ack), 64'b10);
    bus.req = 2'b00;
    wait_idle("t5");

    // 6: reset during WAIT_DONE
    bus.req = 2'b01;
    wait_ack("t6");
    bus.req = 2'b00;
    repeat (5) tick();
    chk("t6_pre_start", 64'(bus.core_start_encrypt), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_start", 64'({bus.core_start_encrypt, bus.core_start_decrypt}), 64'd0);
    chk("t6_key", bus.core_key, 64'd0);
    chk("t6_resp_text", bus.resp_text, 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 2'b11;
    tick();
    chk("t6_tie_ack", 64'(bus.ack), 64'b01);
    bus.req = 2'b00;
    wait_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_core_arbiter.md
Name: des_core_arbiter

Overview:
- Shares one DES control core (start_encrypt/start_decrypt/done_encrypt/done_decrypt, 64-bit key, input_text and output_text) between two independent requesters.
- Round-robin arbitration between the requesters.
- Registers the key and text of the granted request and holds them stable for the whole operation.
- Sequences the core's level-start/level-done handshake, enforces a completion timeout, and returns the result to the owning requester over a valid/ready response channel.

Parameters:
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_DONE before the operation is aborted with error (must be >= 20; the core needs ~19).
- TO_W, 7, width of the timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  2  per-requester request level; held until ack
- req_mode  in  2  per-requester mode: 0=encrypt, 1=decrypt
- req_key  in  128  requester n key at [64n+63:64n]
- req_text  in  128  requester n text at [64n+63:64n]
- ack  out  2  one-cycle pulse; inputs of that requester captured this cycle
- resp_valid  out  2  result available for requester n
- resp_ready  in  2  requester n accepts result
- resp_text  out  64  result text (shared; qualified by resp_valid)
- resp_err  out  1  result is an error (timeout or wrong done flavour); qualified by resp_valid
- core_start_encrypt  out  1  to core
- core_start_decrypt  out  1  to core
- core_key  out  64  registered key to core
- core_text  out  64  registered text to core
- core_done_encrypt  in  1  from core
- core_done_decrypt  in  1  from core
- core_output_text  in  64  from core
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - All outputs 0: ack, resp_valid, resp_err, core starts, core_key, core_text, resp_text; timeout counter 0.
- IDLE:
  - If any req bit set: grant g = the sole requester, or on tie !last_grant.
  - Same cycle: ack[g]=1, capture req_key/req_text/req_mode of g into core_key/core_text/mode; last_grant=g; go to ISSUE.
- ISSUE (1 cycle):
  - Assert core_start_encrypt if mode=0, else core_start_decrypt. Exactly one is asserted.
  - Clear timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - Hold the start line, core_key and core_text stable; increment the timeout counter each cycle.
  - If either done is high: latch core_output_text into resp_text; resp_err=1 if the done flavour mismatches mode, else 0; drop the start line; go to RELEASE.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: drop the start line; resp_text=0, resp_err=1; go to RELEASE.
- RELEASE:
  - Starts held low. Wait until both done inputs are low (core back in IDLE), then go to RESPOND.
  - After a timeout, RELEASE also exits when both done inputs are low, so a hung core does not wedge the arbiter beyond this point.
- RESPOND:
  - resp_valid[g]=1, resp_text/resp_err stable.
  - When resp_ready[g]=1: clear resp_valid and go to IDLE. A new grant is possible the cycle after return to IDLE.
- Invariants:
  - At most one ack bit per cycle; at most one resp_valid bit at any time.
  - core starts never asserted outside ISSUE/WAIT_DONE.
- Simultaneous events:
  - Both requesters request → alternate (0,1,0,1…).
  - A req arriving during an operation waits; req is not sampled outside IDLE.
  - resp_ready asserted before resp_valid is ignored.
- Reset mid-operation: all state is discarded and the pending response is lost. The core is reset by the same rst.

Test Plan:
1. Requester 0 encrypt: key 133457799BBCDFF1, text 0123456789ABCDEF, resp_ready=1 → ack[0] in the request cycle; core_start_encrypt high until done; resp_valid[0] with resp_text=85E813540F0AB405, resp_err=0.
2. Requester 1 decrypt of 85E813540F0AB405 with the same key → core_start_decrypt only; resp_text=0123456789ABCDEF on resp_valid[1].
3. Both req held continuously for 4 operations → grant order 0,1,0,1; core_key/core_text are constant during each WAIT_DONE.
4. Core model stalls (no done) → after TIMEOUT_CYCLES=64 cycles in WAIT_DONE: start drops, resp_valid with resp_err=1 and resp_text=0; the next request is serviced normally.
5. resp_ready held low 10 cycles after a result → resp_valid and resp_text hold; no new ack until ready; busy=1 throughout.
6. rst pulsed during WAIT_DONE → outputs zero immediately; after release, requester 0 wins the tie.
